mmio_uart_tx: RTL and testbench

- Memory-mapped serial output peripheral sitting directly downstream of the computer's data-memory store port.
- Snoops the memwrite/dataadr/writedata bus in parallel with dmem. Stores to TX_ADDR push a byte into a small FIFO. An FSM serialises each byte as an 8N1 UART frame on tx.
- Exposes a status word for software polling and testbench checks.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_pkg;

  // Default store addresses on the 16-bit data bus
  localparam logic [15:0] TX_ADDR_DEF   = 16'hFF00;
  localparam logic [15:0] STAT_ADDR_DEF = 16'hFF02;

  // Status word bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_FULL    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; push and pop may occur in the same cycle.
// Ports: clk, reset (async active-low), push, pop, din -> dout (head),
//        full, empty, count (occupancy).
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the CPU store bus.
// Ports: clk, reset (async active-low), memwrite/dataadr/writedata (store bus),
//        tx (serial line, idle high, registered),
//        status {0.., count[7:4], overflow[3], full[2], empty[1], busy[0]},
//        busy (FSM not idle).
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned   n            = 16,
  parameter logic [n-1:0]  TX_ADDR      = n'(TX_ADDR_DEF),
  parameter logic [n-1:0]  STAT_ADDR    = n'(STAT_ADDR_DEF),
  parameter int unsigned   DEPTH        = 4,
  parameter int unsigned   CLKS_PER_BIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic         tx,
  output logic [n-1:0] status,
  output logic         busy
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  uart_state_t   r_state,   w_state_nxt;
  logic [BW-1:0] r_baud,    w_baud_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift,   w_shift_nxt;
  logic          r_tx,      w_tx_nxt;
  logic          r_ovf,     w_ovf_nxt;

  logic          w_push_req;
  logic          w_clr_req;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_baud_end;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_unused_wdata;

  // Full-width address decode, no aliasing
  assign w_push_req = memwrite && (dataadr == TX_ADDR);
  assign w_clr_req  = memwrite && (dataadr == STAT_ADDR) && writedata[STAT_OVF];
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_unused_wdata = ^writedata[n-1:8];

  sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (writedata[7:0]),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // State register; reset forces tx high immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // Next-state, baud/bit sequencing, pop request and overflow flag
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;
    w_ovf_nxt     = r_ovf;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_state_nxt   = START;
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_state_nxt   = DATA;
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          // Chain straight into the next start bit when data is waiting
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // tx is registered, so it follows the state being entered
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase

    // A drop in the same cycle as a clear leaves the flag set
    if (w_push_req && w_full && !w_pop) w_ovf_nxt = 1'b1;
    else if (w_clr_req)                 w_ovf_nxt = 1'b0;
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE);

  // Status word for software polling
  always_comb begin
    status                                  = '0;
    status[STAT_BUSY]                       = busy;
    status[STAT_EMPTY]                      = w_empty;
    status[STAT_FULL]                       = w_full;
    status[STAT_OVF]                        = r_ovf;
    status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(w_count);
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-timeline reference model,
// per-cycle comparison, directed scenarios and randomized store traffic.
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [15:0] dataadr;
  logic [15:0] writedata;
  logic        tx;
  logic [15:0] status;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_uart_tx #(
    .n            (16),
    .TX_ADDR      (16'hFF00),
    .STAT_ADDR    (16'hFF02),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .tx        (tx),
    .status    (status),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of waiting bytes plus position within the current frame
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 1'b0;

  always @(posedge clk or negedge reset) begin : model
    bit         do_pop, req, clr, was_full;
    logic [7:0] popped;
    if (!reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
      req      = memwrite && (dataadr == 16'hFF00);
      clr      = memwrite && (dataadr == 16'hFF02) && writedata[3];
      popped   = 8'h00;
      if (do_pop) popped = m_q.pop_front();
      if (req && (!was_full || do_pop)) m_q.push_back(writedata[7:0]);
      if (req && was_full && !do_pop) m_ovf = 1'b1;
      else if (clr)                   m_ovf = 1'b0;
      if (do_pop) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_byte   = popped;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else                    m_pos++;
      end
    end
  end

  // Line level for bit slot k of a frame: start, 8 data LSB first, stop
  function automatic logic frame_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic exp_tx();
    return m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
  endfunction

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s       = '0;
    s[7:4]  = 4'(m_q.size());
    s[3]    = m_ovf;
    s[2]    = (m_q.size() == DEPTH);
    s[1]    = (m_q.size() == 0);
    s[0]    = m_active;
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("model_tx",     {15'b0, tx},   {15'b0, exp_tx()});
    check("model_busy",   {15'b0, busy}, {15'b0, m_active});
    check("model_status", status,        exp_status());
  end

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int c;
    c = 0;
    while (busy && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(name, {15'b0, busy}, 16'h0000);
  endtask

  initial begin : stim
    logic [9:0] exp_a5;
    int         cnt;
    bit         hit;
    exp_a5    = 10'b1_10100101_0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_status", status, 16'h0002);
    check("reset_tx",     {15'b0, tx},   16'h0001);
    check("reset_busy",   {15'b0, busy}, 16'h0000);

    // Single byte 0xA5
    store(16'hFF00, 16'h00A5);
    check("a5_busy_after_push", {15'b0, busy}, 16'h0000);
    check("a5_status_queued",   status, 16'h0010);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("a5_tx_c%0d", c), {15'b0, tx}, {15'b0, exp_a5[c / 4]});
    end
    @(negedge clk);
    check("a5_busy_end",   {15'b0, busy}, 16'h0000);
    check("a5_status_end", status, 16'h0002);

    // Back-to-back frames
    @(negedge clk);
    memwrite = 1'b1; dataadr = 16'hFF00; writedata = 16'h0000;
    @(negedge clk);
    writedata = 16'h00FF;
    @(negedge clk);
    memwrite = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 16'(cnt), 16'd80);

    // Overflow: six consecutive stores
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      memwrite = 1'b1; dataadr = 16'hFF00; writedata = 16'(16'h0310 + i);
      @(negedge clk);
    end
    memwrite = 1'b0;
    check("ovf_status_full", status, 16'h004D);
    store(16'hFF02, 16'h0000);
    check("ovf_kept_by_zero_write", status, 16'h004D);
    store(16'hFF02, 16'h0008);
    check("ovf_cleared", status, 16'h0045);
    wait_idle(300, "ovf_drain");

    // Address decode
    store(16'hFF01, 16'h0011);
    store(16'h00FF, 16'h0022);
    store(16'hFF04, 16'h0033);
    @(negedge clk);
    check("dec_status", status, 16'h0002);
    check("dec_tx",     {15'b0, tx}, 16'h0001);

    // Full FIFO with a store on the exact edge STOP ends and pops
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      memwrite = 1'b1; dataadr = 16'hFF00; writedata = 16'(16'h0050 + i);
      @(negedge clk);
    end
    memwrite = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_active && m_pos == FRAME - 1 && m_q.size() == DEPTH) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("fullpop_reached", {15'b0, hit}, 16'h0001);
    memwrite = 1'b1; dataadr = 16'hFF00; writedata = 16'h0077;
    @(negedge clk);
    memwrite = 1'b0;
    check("fullpop_status", status, 16'h0045);
    wait_idle(400, "fullpop_drain");

    // Reset during data bit 3 with bytes queued
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; dataadr = 16'hFF00; writedata = 16'h0000;
      @(negedge clk);
    end
    memwrite = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_active && m_pos == 4 * CPB + 1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached_bit3", {15'b0, hit}, 16'h0001);
    check("rst_tx_low_before", {15'b0, tx}, 16'h0000);
    #2 reset = 1'b0;
    #1;
    check("rst_tx_async",     {15'b0, tx},   16'h0001);
    check("rst_status_async", status,        16'h0002);
    check("rst_busy_async",   {15'b0, busy}, 16'h0000);
    @(negedge clk);
    #2 reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
    check("rst_no_restart", 16'(cnt), 16'd0);

    // Randomized store traffic in bursts of varying density
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if ($urandom_range(99) < 8 + ph * 10) begin
          int sel;
          sel       = $urandom_range(99);
          memwrite  = 1'b1;
          writedata = 16'($urandom);
          if (sel < 60)      dataadr = 16'hFF00;
          else if (sel < 75) dataadr = 16'hFF02;
          else if (sel < 80) dataadr = 16'hFF01;
          else if (sel < 85) dataadr = 16'hFF03;
          else if (sel < 90) dataadr = 16'h7F00;
          else               dataadr = 16'($urandom);
        end else begin
          memwrite = 1'b0;
        end
      end
    end
    @(negedge clk);
    memwrite = 1'b0;
    wait_idle(400, "rand_drain");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
